// File: rtl/discrete_weighted_mixer.sv
// Weighted resistor-ladder mixer: NUM_INPUTS unsigned sources, each scaled by its own
// fixed-point gain, summed with one shared multiplier (one MAC per clock) and
// saturated to OUT_WIDTH bits. Each accepted audio_clk_en strobe produces one mix.
module discrete_weighted_mixer #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned GAIN_WIDTH = 16,
    parameter int unsigned GAIN_FRAC  = 12,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             audio_clk_en,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0]   in,
    input  logic [NUM_INPUTS*GAIN_WIDTH-1:0] gains,
    output logic [OUT_WIDTH-1:0]             out,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned IdxW  = $clog2(NUM_INPUTS);
    localparam int unsigned ProdW = IN_WIDTH + GAIN_WIDTH;
    // Headroom for NUM_INPUTS full-scale products, so the accumulator never wraps.
    localparam int unsigned AccW  = ProdW + IdxW;
    // Wide enough to hold both the shifted sum and the saturation limit.
    localparam int unsigned ExtW  = ((AccW > OUT_WIDTH) ? AccW : OUT_WIDTH) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [AccW-1:0]                 acc_q, acc_d;
    logic [NUM_INPUTS*IN_WIDTH-1:0]  snap_in_q, snap_in_d;
    logic [NUM_INPUTS*GAIN_WIDTH-1:0] snap_gain_q, snap_gain_d;
    logic [OUT_WIDTH-1:0]            out_q, out_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic                            overrun_q, overrun_d;

    logic [IN_WIDTH-1:0]             cur_in;
    logic [GAIN_WIDTH-1:0]           cur_gain;
    logic [ProdW-1:0]                prod;
    logic [ExtW-1:0]                 shifted;
    logic [ExtW-1:0]                 sat_max;

    // Shared multiplier and saturating output scaler.
    always_comb begin
        cur_in   = snap_in_q[idx_q*IN_WIDTH +: IN_WIDTH];
        cur_gain = snap_gain_q[idx_q*GAIN_WIDTH +: GAIN_WIDTH];
        prod     = ProdW'(cur_in) * ProdW'(cur_gain);
        shifted  = ExtW'(acc_q >> GAIN_FRAC);
        sat_max  = ExtW'({OUT_WIDTH{1'b1}});
    end

    // Next-state logic for the mix sequencer and its datapath.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        snap_in_d   = snap_in_q;
        snap_gain_d = snap_gain_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (audio_clk_en) begin
                    snap_in_d   = in;
                    snap_gain_d = gains;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = StMac;
                end
            end
            StMac: begin
                overrun_d = audio_clk_en;
                acc_d     = acc_q + AccW'(prod);
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                overrun_d   = audio_clk_en;
                out_d       = (shifted > sat_max) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
                out_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and datapath registers; reset aborts any mix in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            snap_in_q   <= '0;
            snap_gain_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            snap_in_q   <= snap_in_d;
            snap_gain_q <= snap_gain_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_discrete_weighted_mixer.sv
// Self-checking bench for discrete_weighted_mixer: directed vector table, hand-written
// overrun/snapshot/reset sequences, and random mixes against an arithmetic model.
// Two instances share stimulus: default 32-bit output and a 16-bit output that saturates.
module tb_discrete_weighted_mixer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        audio_clk_en = 1'b0;
    logic [63:0] in_bus = '0;
    logic [63:0] gain_bus = '0;

    logic [31:0] out32;
    logic        vld32, busy32, ovr32;
    logic [15:0] out16;
    logic        vld16, busy16, ovr16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    discrete_weighted_mixer dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_clk_en (audio_clk_en),
        .in           (in_bus),
        .gains        (gain_bus),
        .out          (out32),
        .out_valid    (vld32),
        .busy         (busy32),
        .overrun      (ovr32)
    );

    discrete_weighted_mixer #(.OUT_WIDTH(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_clk_en (audio_clk_en),
        .in           (in_bus),
        .gains        (gain_bus),
        .out          (out16),
        .out_valid    (vld16),
        .busy         (busy16),
        .overrun      (ovr16)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sum of products, truncating shift by 12, clamp to the output range.
    function automatic logic [63:0] model(input logic [63:0] iv, input logic [63:0] gv,
                                          input int ow);
        logic [63:0] s;
        logic [63:0] lim;
        s = 64'd0;
        for (int k = 0; k < N; k++) s += 64'(iv[k*16 +: 16]) * 64'(gv[k*16 +: 16]);
        s   = s >> 12;
        lim = (64'd1 << ow) - 64'd1;
        return (s > lim) ? lim : s;
    endfunction

    // Full mix from a negedge: strobe, scramble inputs mid-mix, check every cycle.
    task automatic run_mix(input logic [63:0] iv, input logic [63:0] gv,
                           input logic [63:0] e32, input logic [63:0] e16, input string nm);
        in_bus = iv;
        gain_bus = gv;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        in_bus   = {$urandom, $urandom};
        gain_bus = {$urandom, $urandom};
        check({nm, " busy e0"}, busy32, 1);
        check({nm, " vld e0"}, vld32, 0);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            check($sformatf("%s busy e%0d", nm, k), {busy32, busy16}, 2'b11);
            check($sformatf("%s vld e%0d", nm, k), {vld32, vld16}, 2'b00);
            check($sformatf("%s ovr e%0d", nm, k), {ovr32, ovr16}, 2'b00);
        end
        @(negedge clk);
        check({nm, " vld done"}, {vld32, vld16}, 2'b11);
        check({nm, " busy done"}, {busy32, busy16}, 2'b00);
        check({nm, " out32"}, out32, e32);
        check({nm, " out16"}, out16, e16);
        @(negedge clk);
        check({nm, " vld after"}, {vld32, vld16}, 2'b00);
        check({nm, " out32 hold"}, out32, e32);
    endtask

    typedef struct {
        logic [63:0] iv;
        logic [63:0] gv;
        logic [63:0] e32;
        logic [63:0] e16;
    } vec_t;

    vec_t tbl[7];

    localparam logic [63:0] T1In    = {16'd400, 16'd300, 16'd200, 16'd100};
    localparam logic [63:0] Unity   = {4{16'h1000}};
    localparam logic [63:0] T2In    = {16'd7, 16'd5000, 16'd1000, 16'd1000};
    localparam logic [63:0] T2Gain  = {16'h1000, 16'h0000, 16'h2000, 16'h0800};

    initial begin
        logic [63:0] iv, gv;

        tbl[0] = '{T1In, Unity, 64'd1000, 64'd1000};
        tbl[1] = '{T2In, T2Gain, 64'd2507, 64'd2507};
        tbl[2] = '{{4{16'hFFFF}}, {4{16'hFFFF}}, 64'd4194176, 64'hFFFF};
        tbl[3] = '{{4{16'd1}}, {4{16'h0FFF}}, 64'd3, 64'd3};
        tbl[4] = '{{32'd0, 16'h8000, 16'h8000}, Unity, 64'd65536, 64'hFFFF};
        tbl[5] = '{{32'd0, 16'h7FFF, 16'h8000}, Unity, 64'd65535, 64'd65535};
        tbl[6] = '{{16'h1234, 16'hBEEF, 16'hFFFF, 16'h0042}, 64'd0, 64'd0, 64'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset out", {out32, out16}, 48'd0);
        check("reset flags", {vld32, busy32, ovr32, vld16, busy16, ovr16}, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 7; i++)
            run_mix(tbl[i].iv, tbl[i].gv, tbl[i].e32, tbl[i].e16, $sformatf("vec%0d", i));

        // Strobe at edge 0, dropped strobe at edge 2 (inputs changed there), new mix at 6
        in_bus = T1In;
        gain_bus = Unity;
        for (int e = 0; e <= 12; e++) begin
            audio_clk_en = (e == 0 || e == 2 || e == 6);
            if (e == 2) begin
                in_bus = '0;
                gain_bus = T2Gain;
            end
            if (e == 6) in_bus = T2In;
            @(negedge clk);
            check($sformatf("ovr seq busy e%0d", e), busy32, (e <= 4) || (e >= 6 && e <= 10));
            check($sformatf("ovr seq ovr e%0d", e), {ovr32, ovr16}, (e == 2) ? 2'b11 : 2'b00);
            check($sformatf("ovr seq vld e%0d", e), vld32, (e == 5 || e == 11));
            if (e == 5) check("ovr seq first out", out32, 64'd1000);
            if (e == 11) check("ovr seq second out", out32, 64'd2507);
        end
        audio_clk_en = 1'b0;

        // Asynchronous reset in the middle of a mix
        run_mix(T1In, Unity, 64'd1000, 64'd1000, "pre-reset");
        in_bus = T1In;
        gain_bus = Unity;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out", out32, 64'd0);
        check("async rst busy", {busy32, busy16}, 2'b00);
        check("async rst vld", vld32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("post rst c%0d", c), {vld32, busy32, out32}, 34'd0);
        end
        run_mix(T2In, T2Gain, 64'd2507, 64'd2507, "fresh");

        // Random mixes against the arithmetic model
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < N; k++) begin
                iv[k*16 +: 16] = 16'($urandom);
                gv[k*16 +: 16] = (r % 3 == 0) ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom);
            end
            run_mix(iv, gv, model(iv, gv, 32), model(iv, gv, 16), $sformatf("rand%0d", r));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
